coax_buffered_rx: RTL and testbench



---
 rtl/coax_pkg.sv | 28 ++
 rtl/coax_rx.sv | 215 +++++++++++++++++++++
 rtl/coax_buffered_rx.sv | 152 +++++++++++++++
 tb/tb_coax_buffered_rx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_pkg.sv
// Shared types and constants for the IBM 3270 coax receiver (coax_rx, coax_buffered_rx).
// Optional build macro used by the including modules: COAX_BUFFERED_RX_ACTIVE_EN.
package coax_pkg;

    localparam int WORD_WIDTH = 10;

    localparam logic [WORD_WIDTH-1:0] ERROR_LOSS_OF_MID_BIT_TRANSITION = 10'h001;
    localparam logic [WORD_WIDTH-1:0] ERROR_PARITY                     = 10'h002;
    localparam logic [WORD_WIDTH-1:0] ERROR_INVALID_END_SEQUENCE       = 10'h004;
    localparam logic [WORD_WIDTH-1:0] ERROR_OVERFLOW                   = 10'h008;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SYNC   = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        END    = 3'd5
    } rx_state_e;

    // True when data plus parity bit carry an odd (odd=1) or even (odd=0) count of ones.
    function automatic logic parity_ok(input logic [WORD_WIDTH-1:0] word,
                                       input logic                  pbit,
                                       input logic                  odd);
        return (((^word) ^ pbit) == odd);
    endfunction

endpackage

// File: rtl/coax_rx.sv
// Manchester line decoder for 3270 coax frames: emits one strobe per good word or error.
// COAX_BUFFERED_RX_ACTIVE_EN adds the `active` frame-in-progress output.
module coax_rx
    import coax_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  parity,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_strobe,
    output logic                  word_first,
    output logic                  error_strobe,
    output logic [WORD_WIDTH-1:0] error_code
`ifdef COAX_BUFFERED_RX_ACTIVE_EN
    ,
    output logic                  active
`endif
);

    localparam int            TW        = $clog2(CLOCKS_PER_BIT);
    localparam logic [TW-1:0] QUARTER   = TW'(CLOCKS_PER_BIT / 4);
    localparam logic [TW-1:0] THREE_Q   = TW'((3 * CLOCKS_PER_BIT) / 4);
    localparam logic [TW-1:0] HALF_NEXT = TW'(CLOCKS_PER_BIT / 2 + 1);
    localparam logic [TW-1:0] LAST      = TW'(CLOCKS_PER_BIT - 1);

    rx_state_e             state_r;
    logic                  rx_meta_r;
    logic                  rx_q_r;
    logic                  rx_prev_r;
    logic [TW-1:0]         timer_r;
    logic                  first_r;
    logic                  second_r;
    logic                  first_word_r;
    logic [2:0]            ones_cnt_r;
    logic [1:0]            viol_step_r;
    logic [3:0]            bit_cnt_r;
    logic [WORD_WIDTH-1:0] shift_r;

    logic mid_edge_s;
    logic bit_end_s;
    logic has_mid_s;
    logic bit_val_s;

    // Bit-cell classification from the two half-bit samples.
    always_comb begin
        mid_edge_s = (rx_q_r ^ rx_prev_r) && (timer_r > QUARTER) && (timer_r < THREE_Q);
        bit_end_s  = (timer_r == LAST);
        has_mid_s  = first_r ^ second_r;
        bit_val_s  = first_r;
    end

    // Line synchroniser, bit timer and frame state machine.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            rx_meta_r    <= 1'b1;
            rx_q_r       <= 1'b1;
            rx_prev_r    <= 1'b1;
            timer_r      <= '0;
            first_r      <= 1'b1;
            second_r     <= 1'b1;
            first_word_r <= 1'b0;
            ones_cnt_r   <= 3'd0;
            viol_step_r  <= 2'd0;
            bit_cnt_r    <= 4'd0;
            shift_r      <= '0;
            word         <= '0;
            word_strobe  <= 1'b0;
            word_first   <= 1'b0;
            error_strobe <= 1'b0;
            error_code   <= '0;
        end else begin
            rx_meta_r    <= rx;
            rx_q_r       <= rx_meta_r;
            rx_prev_r    <= rx_q_r;
            word_strobe  <= 1'b0;
            error_strobe <= 1'b0;
            if (state_r == IDLE) begin
                // A falling edge while hunting is taken as the mid-bit of a '1'.
                if (rx_prev_r && !rx_q_r) begin
                    state_r     <= START;
                    timer_r     <= HALF_NEXT;
                    first_r     <= 1'b1;
                    ones_cnt_r  <= 3'd0;
                    viol_step_r <= 2'd0;
                end
            end else begin
                if (mid_edge_s) begin
                    timer_r <= HALF_NEXT;
                end else if (bit_end_s) begin
                    timer_r <= '0;
                end else begin
                    timer_r <= timer_r + TW'(1);
                end
                if (timer_r == QUARTER) begin
                    first_r <= rx_q_r;
                end
                if (timer_r == THREE_Q) begin
                    second_r <= rx_q_r;
                end
                if (bit_end_s) begin
                    case (state_r)
                        START: begin
                            // Violation appears as cells LL, LH, HH after the run of ones.
                            case (viol_step_r)
                                2'd0: begin
                                    if (has_mid_s && bit_val_s) begin
                                        if (ones_cnt_r != 3'd7) begin
                                            ones_cnt_r <= ones_cnt_r + 3'd1;
                                        end
                                    end else if (!has_mid_s && !first_r && (ones_cnt_r >= 3'd5)) begin
                                        viol_step_r <= 2'd1;
                                    end else begin
                                        state_r <= IDLE;
                                    end
                                end
                                2'd1: begin
                                    if (has_mid_s && !bit_val_s) begin
                                        viol_step_r <= 2'd2;
                                    end else begin
                                        state_r <= IDLE;
                                    end
                                end
                                2'd2: begin
                                    if (!has_mid_s && first_r) begin
                                        state_r      <= SYNC;
                                        first_word_r <= 1'b1;
                                    end else begin
                                        state_r <= IDLE;
                                    end
                                end
                                default: state_r <= IDLE;
                            endcase
                        end
                        SYNC: begin
                            if (!has_mid_s) begin
                                error_strobe <= 1'b1;
                                error_code   <= ERROR_LOSS_OF_MID_BIT_TRANSITION;
                                state_r      <= IDLE;
                            end else if (bit_val_s) begin
                                state_r   <= DATA;
                                bit_cnt_r <= 4'd0;
                            end else begin
                                state_r   <= END;
                                bit_cnt_r <= 4'd0;
                            end
                        end
                        DATA: begin
                            if (!has_mid_s) begin
                                error_strobe <= 1'b1;
                                error_code   <= ERROR_LOSS_OF_MID_BIT_TRANSITION;
                                state_r      <= IDLE;
                            end else begin
                                shift_r <= {shift_r[WORD_WIDTH-2:0], bit_val_s};
                                if (bit_cnt_r == 4'(WORD_WIDTH - 1)) begin
                                    state_r <= PARITY;
                                end else begin
                                    bit_cnt_r <= bit_cnt_r + 4'd1;
                                end
                            end
                        end
                        PARITY: begin
                            if (!has_mid_s) begin
                                error_strobe <= 1'b1;
                                error_code   <= ERROR_LOSS_OF_MID_BIT_TRANSITION;
                                state_r      <= IDLE;
                            end else if (parity_ok(shift_r, bit_val_s, parity)) begin
                                word         <= shift_r;
                                word_strobe  <= 1'b1;
                                word_first   <= first_word_r;
                                first_word_r <= 1'b0;
                                state_r      <= SYNC;
                            end else begin
                                error_strobe <= 1'b1;
                                error_code   <= ERROR_PARITY;
                                state_r      <= IDLE;
                            end
                        end
                        END: begin
                            // Two full bit cells of steady high close the frame.
                            if (!has_mid_s && first_r) begin
                                if (bit_cnt_r == 4'd1) begin
                                    state_r <= IDLE;
                                end else begin
                                    bit_cnt_r <= bit_cnt_r + 4'd1;
                                end
                            end else begin
                                error_strobe <= 1'b1;
                                error_code   <= ERROR_INVALID_END_SEQUENCE;
                                state_r      <= IDLE;
                            end
                        end
                        default: state_r <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef COAX_BUFFERED_RX_ACTIVE_EN
    // Frame-in-progress flag: set once the start violation is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active <= 1'b0;
        end else begin
            active <= (state_r == SYNC) || (state_r == DATA) ||
                      (state_r == PARITY) || (state_r == END);
        end
    end
`endif

endmodule

// File: rtl/coax_buffered_rx.sv
// 3270 coax receiver with first-word-fall-through word FIFO and sticky error code.
// COAX_BUFFERED_RX_ACTIVE_EN adds the `active` output from the line decoder.
module coax_buffered_rx
    import coax_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int DEPTH          = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  read_strobe,
    input  logic                  parity,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  error,
    output logic                  empty,
    output logic                  full
`ifdef COAX_BUFFERED_RX_ACTIVE_EN
    ,
    output logic                  active
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_WIDTH-1:0] word_s;
    logic                  word_strobe_s;
    logic                  word_first_s;
    logic                  error_strobe_s;
    logic [WORD_WIDTH-1:0] error_code_s;

    logic [WORD_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;

    logic                  flush_s;
    logic                  pop_s;
    logic                  overflow_s;
    logic                  push_s;
    logic [AW-1:0]         wr_next_s;
    logic [AW-1:0]         rd_next_s;
    logic [CW-1:0]         count_next_s;
    logic                  error_next_s;
    logic [WORD_WIDTH-1:0] code_next_s;
    logic [WORD_WIDTH-1:0] head_next_s;
    logic [WORD_WIDTH-1:0] data_next_s;

    coax_rx #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .parity      (parity),
        .word        (word_s),
        .word_strobe (word_strobe_s),
        .word_first  (word_first_s),
        .error_strobe(error_strobe_s),
        .error_code  (error_code_s)
`ifdef COAX_BUFFERED_RX_ACTIVE_EN
        ,
        .active      (active)
`endif
    );

    // FIFO control, overflow detection, error latch and next output word.
    always_comb begin
        flush_s    = read_strobe && error;
        pop_s      = read_strobe && !error && !empty;
        overflow_s = word_strobe_s && !flush_s && (full || (word_first_s && !empty));
        push_s     = word_strobe_s && !flush_s && !overflow_s;

        if (flush_s) begin
            wr_next_s = '0;
            rd_next_s = '0;
        end else begin
            wr_next_s = push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        end

        case ({flush_s, push_s, pop_s})
            3'b010:  count_next_s = count_r + CW'(1);
            3'b001:  count_next_s = count_r - CW'(1);
            3'b100,
            3'b101,
            3'b110,
            3'b111:  count_next_s = '0;
            default: count_next_s = count_r;
        endcase

        // First error since the last acknowledge wins; data already holds its code.
        if (error && !flush_s) begin
            error_next_s = 1'b1;
            code_next_s  = data;
        end else if (error_strobe_s) begin
            error_next_s = 1'b1;
            code_next_s  = error_code_s;
        end else if (overflow_s) begin
            error_next_s = 1'b1;
            code_next_s  = ERROR_OVERFLOW;
        end else begin
            error_next_s = 1'b0;
            code_next_s  = '0;
        end

        // The word being written this cycle can already be the next head.
        if (push_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = word_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end

        if (error_next_s) begin
            data_next_s = code_next_s;
        end else if (count_next_s == '0) begin
            data_next_s = '0;
        end else begin
            data_next_s = head_next_s;
        end
    end

    // FIFO storage; contents are only observed through the occupancy-qualified head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // Pointers, occupancy and registered host outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            data     <= '0;
            error    <= 1'b0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            data     <= data_next_s;
            error    <= error_next_s;
            empty    <= (count_next_s == '0);
            full     <= (count_next_s == CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_coax_buffered_rx.sv
// Directed self-checking bench for coax_buffered_rx (CLOCKS_PER_BIT=8, DEPTH=8).
// Connects `active` when COAX_BUFFERED_RX_ACTIVE_EN is defined.
module tb_coax_buffered_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       read_strobe;
    logic       parity;
    logic [9:0] data;
    logic       error;
    logic       empty;
    logic       full;
`ifdef COAX_BUFFERED_RX_ACTIVE_EN
    logic       active;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [9:0] tx_w [16];
    int         tx_n;
    int         tx_bad_par_word;
    int         tx_kill_bit;
    bit         tx_bad_end;

    typedef struct {
        logic       par_mode;
        logic [9:0] word;
        bit         bad_par;
        logic       exp_err;
        logic [9:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    coax_buffered_rx #(
        .CLOCKS_PER_BIT(8),
        .DEPTH         (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .read_strobe(read_strobe),
        .parity     (parity),
        .data       (data),
        .error      (error),
        .empty      (empty),
        .full       (full)
`ifdef COAX_BUFFERED_RX_ACTIVE_EN
        ,
        .active     (active)
`endif
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic [9:0] exp_data,
                                input logic exp_err, input logic exp_empty, input logic exp_full);
        check({name, ".data"},  data, exp_data);
        check({name, ".error"}, {9'd0, error}, {9'd0, exp_err});
        check({name, ".empty"}, {9'd0, empty}, {9'd0, exp_empty});
        check({name, ".full"},  {9'd0, full},  {9'd0, exp_full});
    endtask

    task automatic half(input logic lvl);
        rx = lvl;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        half(b);
        half(!b);
    endtask

    task automatic send_start();
        half(1'b1);
        half(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        half(1'b0); half(1'b0); half(1'b0);
        half(1'b1); half(1'b1); half(1'b1);
    endtask

    task automatic send_frame();
        logic pb;
        send_start();
        for (int w = 0; w < tx_n; w++) begin
            send_bit(1'b1);
            for (int b = 9; b >= 0; b--) begin
                if (w == 0 && b == tx_kill_bit) begin
                    half(1'b1);
                    half(1'b1);
                end else begin
                    send_bit(tx_w[w][b]);
                end
            end
            pb = (^tx_w[w]) ^ parity;
            if (w == tx_bad_par_word) pb = !pb;
            send_bit(pb);
        end
        send_bit(1'b0);
        if (tx_bad_end) begin
            half(1'b0);
            half(1'b0);
        end
        for (int i = 0; i < 6; i++) half(1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic set_plain(input int n);
        tx_n            = n;
        tx_bad_par_word = -1;
        tx_kill_bit     = -1;
        tx_bad_end      = 1'b0;
    endtask

    task automatic pulse_read();
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 10'h155, 1'b0, 1'b0, 10'h155};
        vecs[1] = '{1'b0, 10'h2AA, 1'b0, 1'b0, 10'h2AA};
        vecs[2] = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h3FF};
        vecs[3] = '{1'b0, 10'h001, 1'b1, 1'b1, 10'h002};
        vecs[4] = '{1'b1, 10'h001, 1'b1, 1'b1, 10'h002};
        vecs[5] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000};
        vecs[6] = '{1'b1, 10'h0F0, 1'b0, 1'b0, 10'h0F0};

        rx          = 1'b1;
        read_strobe = 1'b0;
        parity      = 1'b1;
        reset_n     = 1'b1;
        set_plain(0);
        @(negedge clk);
        do_reset();
        check_status("reset", 10'h000, 1'b0, 1'b1, 1'b0);

        // Single-word frames in both parity modes, good and bad parity bits.
        for (int v = 0; v < 7; v++) begin
            parity = vecs[v].par_mode;
            set_plain(1);
            tx_w[0] = vecs[v].word;
            if (vecs[v].bad_par) tx_bad_par_word = 0;
            send_frame();
            check_status($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_err,
                         vecs[v].exp_err, 1'b0);
            pulse_read();
            check_status($sformatf("vec%0d.after_read", v), 10'h000, 1'b0, 1'b1, 1'b0);
        end

        // Eight words fill the FIFO, then drain in order.
        parity = 1'b1;
        set_plain(8);
        for (int i = 0; i < 8; i++) tx_w[i] = 10'(i + 1);
        send_frame();
        check_status("fill8", 10'h001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pop%0d.data", i), data, 10'(i + 1));
            pulse_read();
        end
        check_status("drained", 10'h000, 1'b0, 1'b1, 1'b0);

        // Undrained frame followed by a new frame: overflow, stored words kept.
        set_plain(4);
        for (int i = 0; i < 4; i++) tx_w[i] = 10'h011 + 10'(i);
        send_frame();
        check_status("four", 10'h011, 1'b0, 1'b0, 1'b0);
        set_plain(1);
        tx_w[0] = 10'h020;
        send_frame();
        check_status("newframe_ovf", 10'h008, 1'b1, 1'b0, 1'b0);
        set_plain(1);
        tx_w[0] = 10'h001;
        tx_bad_par_word = 0;
        send_frame();
        check_status("first_err_kept", 10'h008, 1'b1, 1'b0, 1'b0);
        pulse_read();
        check_status("ack_flush", 10'h000, 1'b0, 1'b1, 1'b0);
        set_plain(1);
        tx_w[0] = 10'h123;
        send_frame();
        check_status("after_ack", 10'h123, 1'b0, 1'b0, 1'b0);
        pulse_read();

        // Nine words: ninth overflows a full FIFO.
        set_plain(9);
        for (int i = 0; i < 9; i++) tx_w[i] = 10'h000;
        send_frame();
        check_status("nine", 10'h008, 1'b1, 1'b0, 1'b1);
        pulse_read();
        check_status("nine.ack", 10'h000, 1'b0, 1'b1, 1'b0);

        // Missing mid-bit transition inside a data bit.
        set_plain(1);
        tx_w[0]     = 10'h0AB;
        tx_kill_bit = 5;
        send_frame();
        check_status("loss_mid", 10'h001, 1'b1, 1'b1, 1'b0);
        pulse_read();

        // Good word, then the line drops after the end bit.
        set_plain(1);
        tx_w[0]    = 10'h05A;
        tx_bad_end = 1'b1;
        send_frame();
        check_status("bad_end", 10'h004, 1'b1, 1'b0, 1'b0);
        pulse_read();
        check_status("bad_end.ack", 10'h000, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a word discards stored words and the partial frame.
        set_plain(1);
        tx_w[0] = 10'h0C3;
        send_frame();
        check_status("pre_reset", 10'h0C3, 1'b0, 1'b0, 1'b0);
        send_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        check_status("in_reset", 10'h000, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        reset_n = 1'b1;
        repeat (24) @(negedge clk);
        check_status("post_reset", 10'h000, 1'b0, 1'b1, 1'b0);
        set_plain(2);
        tx_w[0] = 10'h2C5;
        tx_w[1] = 10'h13A;
        send_frame();
        check_status("post_reset_frame", 10'h2C5, 1'b0, 1'b0, 1'b0);
        pulse_read();
        check("post_reset_frame.second", data, 10'h13A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
